// File: rtl/leap_counter_bank.sv
// rtl/leap_counter_bank.sv - bank of NCH counters with jump reload and snapshot handshake
// Optional: define LEAP_CNT_SATURATE_EN to saturate at all-ones instead of wrapping.
module leap_counter_bank #(
  parameter int CW  = 32,
  parameter int NCH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exe_start_as,
  input  logic [NCH-1:0]    inc,
  input  logic              call_as_cb,
  input  logic              retn_as_cb,
  input  logic [NCH*CW-1:0] init_count_on_jump,
  output logic [NCH*CW-1:0] count,
  output logic [NCH*CW-1:0] snap,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic              snap_lost,
  output logic [NCH-1:0]    sat
);

  logic [NCH*CW-1:0] cnt_q;
  logic [NCH*CW-1:0] snap_q;
  logic              valid_q;
  logic              lost_q;
  logic              jump;

  // Jumps only count while execution is active; call and return merge into one event.
  assign jump = exe_start_as & (call_as_cb | retn_as_cb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!exe_start_as) begin
          cnt_q[i*CW +: CW] <= '0;
        end else if (jump) begin
          cnt_q[i*CW +: CW] <= init_count_on_jump[i*CW +: CW];
        end else if (inc[i]) begin
`ifdef LEAP_CNT_SATURATE_EN
          if (!(&cnt_q[i*CW +: CW])) begin
            cnt_q[i*CW +: CW] <= cnt_q[i*CW +: CW] + CW'(1);
          end
`else
          cnt_q[i*CW +: CW] <= cnt_q[i*CW +: CW] + CW'(1);
`endif
        end
      end
    end
  end

`ifdef LEAP_CNT_SATURATE_EN
  logic [NCH-1:0] sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!exe_start_as) begin
          sat_q[i] <= 1'b0;
        end else if (!jump && inc[i] && (&cnt_q[i*CW +: CW])) begin
          sat_q[i] <= 1'b1;
        end
      end
    end
  end

  assign sat = sat_q;
`else
  assign sat = '0;
`endif

  // Snapshot holds the pre-load counts; a jump wins over a same-cycle consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      if (jump) begin
        snap_q  <= cnt_q;
        valid_q <= 1'b1;
      end else if (valid_q && snap_ready) begin
        valid_q <= 1'b0;
      end

      if (!exe_start_as) begin
        lost_q <= 1'b0;
      end else if (jump && valid_q && !snap_ready) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign count      = cnt_q;
  assign snap       = snap_q;
  assign snap_valid = valid_q;
  assign snap_lost  = lost_q;

endmodule

// File: tb/tb_leap_counter_bank.sv
// tb/tb_leap_counter_bank.sv - directed self-checking bench for leap_counter_bank (CW=8, NCH=2)
module tb_leap_counter_bank;

  localparam int CW  = 8;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              exe_start_as;
  logic [NCH-1:0]    inc;
  logic              call_as_cb;
  logic              retn_as_cb;
  logic [NCH*CW-1:0] init_count_on_jump;
  logic [NCH*CW-1:0] count;
  logic [NCH*CW-1:0] snap;
  logic              snap_valid;
  logic              snap_ready;
  logic              snap_lost;
  logic [NCH-1:0]    sat;

  int total = 0;
  int bad   = 0;

  leap_counter_bank #(.CW(CW), .NCH(NCH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .exe_start_as       (exe_start_as),
    .inc                (inc),
    .call_as_cb         (call_as_cb),
    .retn_as_cb         (retn_as_cb),
    .init_count_on_jump (init_count_on_jump),
    .count              (count),
    .snap               (snap),
    .snap_valid         (snap_valid),
    .snap_ready         (snap_ready),
    .snap_lost          (snap_lost),
    .sat                (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    inc        = '0;
    call_as_cb = 1'b0;
    retn_as_cb = 1'b0;
    snap_ready = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    exe_start_as       = 1'b1;
    init_count_on_jump = '0;
    idle();
    tick(2);
    chk("rst_count", count, 16'h0000);
    chk("rst_snap", snap, 16'h0000);
    chk("rst_valid", snap_valid, 1'b0);
    chk("rst_lost", snap_lost, 1'b0);
    chk("rst_sat", sat, 2'b00);
    #2 reset_n = 1'b1;
    tick(1);

    // Both channels count, then only channel 0.
    inc = 2'b11;
    tick(5);
    chk("inc_both", count, 16'h0505);
    inc = 2'b01;
    tick(3);
    chk("inc_ch0", count, 16'h0508);

    // Jump with concurrent inc: load wins, snapshot is the pre-load value.
    inc = 2'b11; call_as_cb = 1'b1; init_count_on_jump = 16'h1010;
    tick(1);
    idle();
    chk("jump_count", count, 16'h1010);
    chk("jump_snap", snap, 16'h0508);
    chk("jump_valid", snap_valid, 1'b1);

    // Execution inactive: jump ignored, counts cleared, snapshot untouched.
    exe_start_as = 1'b0; call_as_cb = 1'b1; init_count_on_jump = 16'h7777;
    tick(1);
    idle();
    exe_start_as = 1'b1;
    chk("exe_clr_count", count, 16'h0000);
    chk("exe_clr_snap", snap, 16'h0508);
    chk("exe_clr_valid", snap_valid, 1'b1);

    // Build {3,4} then jump while snapshot pending and not ready: overwrite and lost.
    inc = 2'b11;
    tick(3);
    inc = 2'b01;
    tick(1);
    chk("pre_lost_count", count, 16'h0304);
    inc = 2'b00; retn_as_cb = 1'b1; init_count_on_jump = 16'h2020;
    tick(1);
    idle();
    chk("lost_snap", snap, 16'h0304);
    chk("lost_flag", snap_lost, 1'b1);
    chk("lost_valid", snap_valid, 1'b1);
    chk("lost_count", count, 16'h2020);
    snap_ready = 1'b1;
    tick(1);
    idle();
    chk("consume_valid", snap_valid, 1'b0);
    chk("consume_lost", snap_lost, 1'b1);

    // Clear lost via inactive execution, then jump + consume in the same cycle.
    exe_start_as = 1'b0;
    tick(1);
    exe_start_as = 1'b1;
    chk("lost_cleared", snap_lost, 1'b0);
    call_as_cb = 1'b1; init_count_on_jump = 16'h4141;
    tick(1);
    idle();
    chk("j1_snap", snap, 16'h0000);
    chk("j1_valid", snap_valid, 1'b1);
    call_as_cb = 1'b1; retn_as_cb = 1'b1; snap_ready = 1'b1; init_count_on_jump = 16'h3030;
    tick(1);
    idle();
    chk("jr_snap", snap, 16'h4141);
    chk("jr_valid", snap_valid, 1'b1);
    chk("jr_lost", snap_lost, 1'b0);
    chk("jr_count", count, 16'h3030);

    // Channel 0 at all-ones with inc: wrap or saturate depending on build.
    call_as_cb = 1'b1; snap_ready = 1'b1; init_count_on_jump = 16'h01FF;
    tick(1);
    idle();
    chk("pre_wrap_count", count, 16'h01FF);
    chk("pre_wrap_lost", snap_lost, 1'b0);
    inc = 2'b01; snap_ready = 1'b1;
    tick(1);
    idle();
`ifdef LEAP_CNT_SATURATE_EN
    chk("sat_count", count, 16'h01FF);
    chk("sat_flag", sat, 2'b01);
`else
    chk("wrap_count", count, 16'h0100);
    chk("wrap_sat", sat, 2'b00);
`endif
    chk("wrap_valid", snap_valid, 1'b0);

    // Asynchronous reset mid-cycle with a pending snapshot and nonzero counts.
    call_as_cb = 1'b1; init_count_on_jump = 16'h1234;
    tick(1);
    idle();
    chk("pre_rst_valid", snap_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 16'h0000);
    chk("arst_snap", snap, 16'h0000);
    chk("arst_valid", snap_valid, 1'b0);
    chk("arst_lost", snap_lost, 1'b0);
    chk("arst_sat", sat, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);

    // First event after release behaves normally.
    call_as_cb = 1'b1; init_count_on_jump = 16'h5566;
    tick(1);
    idle();
    chk("post_rst_count", count, 16'h5566);
    chk("post_rst_snap", snap, 16'h0000);
    chk("post_rst_valid", snap_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
